// File: rtl/common_pkg.sv
// Shared types for the PDP memory path: access kinds, sizes,
// data words and the responder state encoding.
package common_pkg;

  typedef enum logic [1:0] {
    DATA_READ         = 2'd0,
    DATA_WRITE        = 2'd1,
    INSTRUCTION_FETCH = 2'd2
  } mem_access_t;

  typedef enum logic {
    word_op = 1'b0,
    byte_op = 1'b1
  } op_size;

  typedef logic [15:0] word_t;
  typedef logic [7:0]  mem_data_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACC_LO = 2'd1,
    ACC_HI = 2'd2,
    RESP   = 2'd3
  } rsp_state_t;

  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  function automatic logic [31:0] sat_inc(
    input logic [31:0] v
  );
    return (v == CNT_MAX) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/pdp_byte_ram.sv
// Byte-wide storage: synchronous write, combinational read,
// no reset so contents survive responder resets.
module pdp_byte_ram
  import common_pkg::*;
#(
  parameter int MEM_BYTES = 65536,
  parameter int AW        = 16
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AW-1:0]   addr,
  input  mem_data_t       wdata,
  output mem_data_t       rdata
);

  mem_data_t mem [MEM_BYTES];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/pdp_mem_responder.sv
// Single-outstanding memory responder: splits word accesses
// into two little-endian byte cycles on a byte RAM.
module pdp_mem_responder
  import common_pkg::*;
#(
  parameter int MEM_BYTES = 65536
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  mem_access_t req_type,
  input  op_size      req_size,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] fetch_cnt,
  output logic [31:0] read_cnt,
  output logic [31:0] write_cnt
);

  localparam int AW =
    (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
  localparam logic [16:0] LIMIT = 17'(MEM_BYTES);

  rsp_state_t  state_q;
  rsp_state_t  state_d;
  mem_access_t type_q;
  op_size      size_q;
  word_t       addr_q;
  word_t       wdata_q;
  word_t       rdata_q;
  logic        err_q;
  logic [31:0] fetch_q;
  logic [31:0] read_q;
  logic [31:0] write_q;

  logic        accept;
  logic        rsp_fire;
  logic        in_word;
  logic [16:0] req_end;
  logic        req_err;
  logic        is_wr;
  word_t       hi_addr;

  logic          ram_we;
  logic [AW-1:0] ram_addr;
  mem_data_t     ram_wdata;
  mem_data_t     ram_rdata;

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign accept    = req_valid & req_ready;
  assign rsp_fire  = rsp_valid & rsp_ready;

  // Last byte touched decides range; 17 bits so 0xFFFF+1 cannot wrap
  assign in_word = (req_size == word_op);
  assign req_end = {1'b0, req_addr} + {16'd0, in_word};
  assign req_err = (in_word & req_addr[0])
                 | (req_end >= LIMIT);

  assign is_wr   = (type_q == DATA_WRITE);
  assign hi_addr = addr_q + 16'd1;

  always_comb begin
    ram_addr  = addr_q[AW-1:0];
    ram_wdata = wdata_q[7:0];
    ram_we    = 1'b0;
    unique case (1'b1)
      (state_q == ACC_LO): begin
        ram_we = is_wr & reset_n;
      end
      (state_q == ACC_HI): begin
        ram_addr  = hi_addr[AW-1:0];
        ram_wdata = wdata_q[15:8];
        ram_we    = is_wr & reset_n;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = req_err ? RESP : ACC_LO;
        end
      end
      ACC_LO: begin
        state_d = (size_q == word_op) ? ACC_HI : RESP;
      end
      ACC_HI: state_d = RESP;
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      type_q  <= DATA_READ;
      size_q  <= byte_op;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        type_q  <= req_type;
        size_q  <= req_size;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        rdata_q <= '0;
        err_q   <= req_err;
      end
      if (state_q == ACC_LO && !is_wr) begin
        rdata_q[7:0] <= ram_rdata;
      end
      if (state_q == ACC_HI && !is_wr) begin
        rdata_q[15:8] <= ram_rdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fetch_q <= '0;
      read_q  <= '0;
      write_q <= '0;
    end else if (rsp_fire && !err_q) begin
      case (type_q)
        DATA_READ:
          read_q  <= sat_inc(read_q);
        DATA_WRITE:
          write_q <= sat_inc(write_q);
        INSTRUCTION_FETCH:
          fetch_q <= sat_inc(fetch_q);
        default: ;
      endcase
    end
  end

  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign fetch_cnt = fetch_q;
  assign read_cnt  = read_q;
  assign write_cnt = write_q;

  pdp_byte_ram #(
    .MEM_BYTES (MEM_BYTES),
    .AW        (AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_pdp_mem_responder.sv
// Bench for pdp_mem_responder: directed table, corner sequences,
// and random traffic against a byte-array reference model.
module tb_pdp_mem_responder;
  import common_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  mem_access_t req_type;
  op_size      req_size;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] fetch_cnt, read_cnt, write_cnt;

  logic        s_valid, s_ready, s_rsp_valid, s_rsp_ready;
  mem_access_t s_type;
  op_size      s_size;
  logic [15:0] s_addr, s_wdata, s_rdata;
  logic        s_err;
  logic [31:0] s_fc, s_rc, s_wc;

  int tests = 0;
  int fails = 0;

  logic [7:0] m [65536];
  int mfc, mrc, mwc;

  always #5 clk = ~clk;

  pdp_mem_responder dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_type(req_type), .req_size(req_size),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .fetch_cnt(fetch_cnt), .read_cnt(read_cnt),
    .write_cnt(write_cnt)
  );

  pdp_mem_responder #(.MEM_BYTES(4096)) dut_s (
    .clk(clk), .reset_n(reset_n),
    .req_valid(s_valid), .req_ready(s_ready),
    .req_type(s_type), .req_size(s_size),
    .req_addr(s_addr), .req_wdata(s_wdata),
    .rsp_valid(s_rsp_valid), .rsp_ready(s_rsp_ready),
    .rsp_rdata(s_rdata), .rsp_err(s_err),
    .fetch_cnt(s_fc), .read_cnt(s_rc),
    .write_cnt(s_wc)
  );

  typedef struct {
    mem_access_t t;
    op_size      s;
    logic [15:0] a;
    logic [15:0] wd;
    int          hold;
    logic [15:0] rd;
    logic        er;
    int          lat;
    int          fc, rc, wc;
  } vec_t;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic poke(input int a, input logic [7:0] v);
    m[a] = v;
    dut.u_ram.mem[a] = v;
  endtask

  task automatic model_txn(input mem_access_t t,
                           input op_size s,
                           input logic [15:0] a,
                           input logic [15:0] wd,
                           output logic [15:0] rd,
                           output logic er,
                           output int lat);
    bit w;
    int ai;
    w   = (s == word_op);
    ai  = int'(a);
    er  = (w && a[0]) || (ai + (w ? 1 : 0) >= 65536);
    lat = er ? 1 : (w ? 3 : 2);
    rd  = 16'h0;
    if (!er) begin
      if (t == DATA_WRITE) begin
        m[ai] = wd[7:0];
        if (w) m[ai+1] = wd[15:8];
        mwc++;
      end else begin
        rd = w ? {m[ai+1], m[ai]} : {8'h00, m[ai]};
        if (t == DATA_READ) mrc++;
        if (t == INSTRUCTION_FETCH) mfc++;
      end
    end
  endtask

  // Called at posedge+1 with the DUT idle
  task automatic txn(input string nm,
                     input mem_access_t t,
                     input op_size s,
                     input logic [15:0] a,
                     input logic [15:0] wd,
                     input int hold,
                     input logic [15:0] erd,
                     input logic eer,
                     input int elat);
    int n;
    int lat;
    req_type  = t;
    req_size  = s;
    req_addr  = a;
    req_wdata = wd;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk({nm, " req_ready"}, 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    chk({nm, " latency"}, 32'(lat), 32'(elat));
    chk({nm, " rdata"}, 32'(rsp_rdata), 32'(erd));
    chk({nm, " err"}, 32'(rsp_err), 32'(eer));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({nm, " hold valid"}, 32'(rsp_valid), 32'd1);
      chk({nm, " hold rdata"}, 32'(rsp_rdata), 32'(erd));
      chk({nm, " hold err"}, 32'(rsp_err), 32'(eer));
      chk({nm, " hold req_ready"}, 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk({nm, " post req_ready"}, 32'(req_ready), 32'd1);
    chk({nm, " post rsp_valid"}, 32'(rsp_valid), 32'd0);
  endtask

  task automatic s_read(input string nm,
                        input logic [15:0] a,
                        input logic eer,
                        input int elat);
    int lat;
    s_addr  = a;
    s_valid = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b0;
    lat = 1;
    while (!s_rsp_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    chk({nm, " latency"}, 32'(lat), 32'(elat));
    chk({nm, " err"}, 32'(s_err), 32'(eer));
    @(posedge clk); #1;
    chk({nm, " idle"}, 32'(s_ready), 32'd1);
  endtask

  initial begin
    vec_t        v [12];
    logic [15:0] rd;
    logic        er;
    int          lat;

    reset_n     = 1'b0;
    req_valid   = 1'b0;
    req_type    = DATA_READ;
    req_size    = byte_op;
    req_addr    = '0;
    req_wdata   = '0;
    rsp_ready   = 1'b0;
    s_valid     = 1'b0;
    s_type      = DATA_READ;
    s_size      = byte_op;
    s_addr      = '0;
    s_wdata     = '0;
    s_rsp_ready = 1'b1;
    mfc = 0; mrc = 0; mwc = 0;

    for (int i = 0; i < 65536; i++) poke(i, 8'($urandom));
    poke(16'h1000, 8'h34);
    poke(16'h1001, 8'h12);
    poke(16'h2000, 8'h77);
    poke(16'h2001, 8'h88);
    poke(16'hFFFE, 8'h11);
    poke(16'hFFFF, 8'h5E);

    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;

    chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset req_ready", 32'(req_ready), 32'd1);
    chk("reset rdata", 32'(rsp_rdata), 32'd0);
    chk("reset err", 32'(rsp_err), 32'd0);
    chk("reset counters",
        fetch_cnt | read_cnt | write_cnt, 32'd0);

    v[0]  = '{INSTRUCTION_FETCH, word_op, 16'h1000, 16'h0,
              0, 16'h1234, 1'b0, 3, 1, 0, 0};
    v[1]  = '{DATA_WRITE, byte_op, 16'h2001, 16'hABCD,
              0, 16'h0000, 1'b0, 2, 1, 0, 1};
    v[2]  = '{DATA_READ, word_op, 16'h2000, 16'h0,
              5, 16'hCD77, 1'b0, 3, 1, 1, 1};
    v[3]  = '{DATA_READ, word_op, 16'h0003, 16'h0,
              1, 16'h0000, 1'b1, 1, 1, 1, 1};
    v[4]  = '{DATA_READ, byte_op, 16'hFFFF, 16'h0,
              0, 16'h005E, 1'b0, 2, 1, 2, 1};
    v[5]  = '{DATA_READ, word_op, 16'hFFFE, 16'h0,
              0, 16'h5E11, 1'b0, 3, 1, 3, 1};
    v[6]  = '{DATA_WRITE, word_op, 16'h4000, 16'hBEEF,
              0, 16'h0000, 1'b0, 3, 1, 3, 2};
    v[7]  = '{DATA_READ, word_op, 16'h4000, 16'h0,
              0, 16'hBEEF, 1'b0, 3, 1, 4, 2};
    v[8]  = '{INSTRUCTION_FETCH, byte_op, 16'h4001, 16'h0,
              0, 16'h00BE, 1'b0, 2, 2, 4, 2};
    v[9]  = '{mem_access_t'(2'd3), byte_op, 16'h4000, 16'h0,
              0, 16'h00EF, 1'b0, 2, 2, 4, 2};
    v[10] = '{DATA_WRITE, word_op, 16'h4001, 16'h1111,
              0, 16'h0000, 1'b1, 1, 2, 4, 2};
    v[11] = '{DATA_READ, word_op, 16'h4000, 16'h0,
              0, 16'hBEEF, 1'b0, 3, 2, 5, 2};

    for (int i = 0; i < 12; i++) begin
      model_txn(v[i].t, v[i].s, v[i].a, v[i].wd, rd, er, lat);
      txn($sformatf("vec%0d", i), v[i].t, v[i].s, v[i].a,
          v[i].wd, v[i].hold, v[i].rd, v[i].er, v[i].lat);
      chk($sformatf("vec%0d fetch_cnt", i), fetch_cnt,
          32'(v[i].fc));
      chk($sformatf("vec%0d read_cnt", i), read_cnt,
          32'(v[i].rc));
      chk($sformatf("vec%0d write_cnt", i), write_cnt,
          32'(v[i].wc));
    end

    // Reset lands while the high byte of a word write is pending
    poke(16'h3000, 8'h11);
    poke(16'h3001, 8'h22);
    req_type  = DATA_WRITE;
    req_size  = word_op;
    req_addr  = 16'h3000;
    req_wdata = 16'h5A5A;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    chk("midreset rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midreset req_ready", 32'(req_ready), 32'd1);
    chk("midreset counters",
        fetch_cnt | read_cnt | write_cnt, 32'd0);
    m[16'h3000] = 8'h5A;
    mfc = 0; mrc = 0; mwc = 0;
    model_txn(DATA_READ, word_op, 16'h3000, 16'h0, rd, er, lat);
    txn("midreset read", DATA_READ, word_op, 16'h3000,
        16'h0, 0, 16'h225A, 1'b0, 3);
    chk("midreset read_cnt", read_cnt, 32'd1);

    s_read("small 0x1000", 16'h1000, 1'b1, 1);
    s_read("small 0x0FFF", 16'h0FFF, 1'b0, 2);

    for (int i = 0; i < 300; i++) begin
      mem_access_t t;
      op_size      s;
      logic [15:0] a;
      logic [15:0] wd;
      int          pick;
      t    = mem_access_t'(2'($urandom_range(0, 3)));
      s    = op_size'(1'($urandom_range(0, 1)));
      wd   = 16'($urandom);
      pick = $urandom_range(0, 9);
      if (pick == 0)      a = 16'hFFFF;
      else if (pick == 1) a = 16'hFFFE;
      else if (pick == 2) a = 16'($urandom) | 16'h1;
      else if (pick < 6)  a = 16'h3F00 | 16'($urandom_range(0, 255));
      else                a = 16'($urandom);
      model_txn(t, s, a, wd, rd, er, lat);
      txn($sformatf("rnd%0d", i), t, s, a, wd,
          $urandom_range(0, 2), rd, er, lat);
      chk($sformatf("rnd%0d fetch_cnt", i), fetch_cnt, 32'(mfc));
      chk($sformatf("rnd%0d read_cnt", i), read_cnt, 32'(mrc));
      chk($sformatf("rnd%0d write_cnt", i), write_cnt, 32'(mwc));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
